markov_channel_fsm: RTL
=======================

# markov_channel_fsm

Parametrised N-state Markov (generalised Gilbert-Elliott) channel-quality model for the FPGA channel emulator. Once per enabled cycle, a random sample from the upstream LFSR drives transitions between quality states ordered best (0) to worst (NUM_STATES-1). Each state drives a runtime-programmable SNR level to the noise-injection stage. The block also keeps dwell-time and burst-entry statistics for the host.

## Interface
- NUM_STATES, 2, number of channel states, legal range 2..8
- RAND_W, 7, width of the random sample and of the thresholds
- OUT_W, 8, width of level values and of cfg_wdata
- STAT_W, 16, width of the statistics counters
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- en  in  1  advance strobe; the FSM evaluates only when en=1
- rand_in  in  RAND_W  random sample, unsigned
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  2  register select: 0 = deg_thr, 1 = imp_thr, 2 = level, 3 = reserved (write ignored)
- cfg_idx  in  3  target state index; a write with idx >= NUM_STATES is ignored
- cfg_wdata  in  OUT_W  write data; thresholds take bits [RAND_W-1:0]
- stat_clr  in  1  synchronous clear of bad_entries
- state_out  out  3  current state index
- level_out  out  OUT_W  level[state_out], combinational lookup of registered values
- trans_pulse  out  1  registered one-cycle pulse after each state change
- dwell_cnt  out  STAT_W  en-cycles spent in the current state
- bad_entries  out  STAT_W  count of entries into state NUM_STATES-1

## Operation
- Per-state registers, all reset to fixed defaults:
  - deg_thr[i] = 97
  - imp_thr[i] = 25
  - level[0] = 21, level[i>0] = 9
- Next-state rule in state i when en=1, using unsigned compares:
  - if i < NUM_STATES-1 and rand_in >= deg_thr[i]: go to i+1 (degrade)
  - else if i > 0 and rand_in < imp_thr[i]: go to i-1 (improve)
  - else: stay in i
- Degrade has priority over improve. Moves are at most one state per evaluation.
- en=0: state, dwell_cnt and bad_entries hold; trans_pulse=0.
- A state register value >= NUM_STATES is unreachable. If it occurs, the next clock forces state 0.
- dwell_cnt:
  - on a transition: loads 0
  - on an en-cycle without a transition: increments, saturating at 2^STAT_W-1
- bad_entries: increments, saturating, on each transition into state NUM_STATES-1.
- stat_clr clears bad_entries. If stat_clr coincides with an increment, the clear wins and the result is 0.
- Configuration writes land at the clock edge.
  - An en evaluation in the same cycle uses the old values.
  - level_out reflects a write to the current state's level from the next cycle.

## Timing
- Reset values:
  - state_out = 0
  - level_out = 21
  - trans_pulse = 0
  - dwell_cnt = 0
  - bad_entries = 0
  - all config registers at their defaults
- Reset is asynchronous. Asserting it mid-operation returns every register to its default immediately, including config registers.
- The state update takes one clock: a sample on edge k is reflected in state_out after edge k.
- level_out has zero additional latency relative to state_out.
- trans_pulse is high in the same cycle that state_out shows the new state, for exactly one cycle.
- Back-to-back transitions on consecutive en-cycles are legal. trans_pulse then stays high for each of those cycles.

## Test plan
- Default config, NUM_STATES=2:
  - en=1, rand_in=96 for 5 cycles -> state stays 0, level_out=21, dwell_cnt=5
  - then rand_in=97 -> state 1, level_out=9, trans_pulse=1 for one cycle, dwell_cnt=0, bad_entries=1
- Improve boundary, state 1:
  - rand_in=25 -> stays in state 1
  - rand_in=24 -> state 0, level_out=21
  - en=0 with rand_in=0 -> no change
- NUM_STATES=4, with imp_thr[1]=100 and deg_thr[1]=100:
  - rand_in=127 from state 0 -> 1 -> 2 -> 3 on consecutive cycles; trans_pulse high 3 cycles; bad_entries=1
  - further rand_in=127 -> state stays 3
- Config write:
  - write level[0]=50 with the FSM in state 0 -> level_out=50 next cycle
  - write deg_thr[0]=10 in the same cycle as en=1, rand_in=20 -> no transition (old value 97 used); repeat one cycle later -> transition to state 1
  - write with cfg_idx=5, NUM_STATES=4 -> ignored
- STAT_W=4:
  - hold state 0 for 20 en-cycles -> dwell_cnt saturates at 15
  - stat_clr coincident with an entry into the worst state -> bad_entries=0
- Assert reset while in state 3 with modified config -> all outputs and registers at reset defaults immediately; level_out=21.

Source files
------------

// File: rtl/markov_channel_fsm_if.sv
// Control, config and status bundle for the Markov channel-quality model.
// The master drives strobes and config; the slave returns state, level and statistics.
interface markov_channel_fsm_if #(
   parameter int RAND_W = 7,
   parameter int OUT_W  = 8,
   parameter int STAT_W = 16
);
   logic              en;
   logic [RAND_W-1:0] rand_in;
   logic              cfg_we;
   logic [1:0]        cfg_sel;
   logic [2:0]        cfg_idx;
   logic [OUT_W-1:0]  cfg_wdata;
   logic              stat_clr;
   logic [2:0]        state_out;
   logic [OUT_W-1:0]  level_out;
   logic              trans_pulse;
   logic [STAT_W-1:0] dwell_cnt;
   logic [STAT_W-1:0] bad_entries;

   modport master (
      output en, rand_in, cfg_we, cfg_sel, cfg_idx, cfg_wdata, stat_clr,
      input  state_out, level_out, trans_pulse, dwell_cnt, bad_entries
   );

   modport slave (
      input  en, rand_in, cfg_we, cfg_sel, cfg_idx, cfg_wdata, stat_clr,
      output state_out, level_out, trans_pulse, dwell_cnt, bad_entries
   );
endinterface

// File: rtl/markov_channel_fsm.sv
// N-state Gilbert-Elliott channel model: one move per en-cycle, level per state, dwell/burst stats.
// State updates one clock after the sample; level_out is a zero-latency lookup; no backpressure (en strobes).
module markov_channel_fsm #(
   parameter int NUM_STATES = 2,
   parameter int RAND_W     = 7,
   parameter int OUT_W      = 8,
   parameter int STAT_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   markov_channel_fsm_if.slave bus
);
   typedef enum logic [1:0] {MV_STAY, MV_DEG, MV_IMP, MV_RECOVER} move_t;

   localparam logic [2:0]        LAST     = 3'(NUM_STATES - 1);
   localparam logic [RAND_W-1:0] DEG_RST  = RAND_W'(97);
   localparam logic [RAND_W-1:0] IMP_RST  = RAND_W'(25);
   localparam logic [OUT_W-1:0]  LVL0_RST = OUT_W'(21);
   localparam logic [OUT_W-1:0]  LVLN_RST = OUT_W'(9);

   logic [RAND_W-1:0] r_deg_thr [NUM_STATES];
   logic [RAND_W-1:0] r_imp_thr [NUM_STATES];
   logic [OUT_W-1:0]  r_level   [NUM_STATES];

   logic [2:0]        r_state;
   logic              r_trans_pulse;
   logic [STAT_W-1:0] r_dwell_cnt;
   logic [STAT_W-1:0] r_bad_entries;

   logic [2:0]        w_state_nxt;
   move_t             w_move;
   logic              w_trans;
   logic              w_valid;
   logic [RAND_W-1:0] w_deg_cur;
   logic [RAND_W-1:0] w_imp_cur;
   logic [OUT_W-1:0]  w_level_cur;

   // Per-state lookup via compare loop so a corrupt state index never reads out of range.
   always_comb begin
      w_deg_cur   = DEG_RST;
      w_imp_cur   = IMP_RST;
      w_level_cur = r_level[0];
      for (int i = 0; i < NUM_STATES; i++) begin
         if (r_state == 3'(i)) begin
            w_deg_cur   = r_deg_thr[i];
            w_imp_cur   = r_imp_thr[i];
            w_level_cur = r_level[i];
         end
      end
   end

   assign w_valid = ({1'b0, r_state} < 4'(NUM_STATES));

   always_comb begin
      w_move      = MV_STAY;
      w_state_nxt = r_state;
      if (!w_valid) begin
         w_move      = MV_RECOVER;
         w_state_nxt = 3'd0;
      end else if (bus.en) begin
         if (r_state < LAST && bus.rand_in >= w_deg_cur) begin
            w_move      = MV_DEG;
            w_state_nxt = r_state + 3'd1;
         end else if (r_state != 3'd0 && bus.rand_in < w_imp_cur) begin
            w_move      = MV_IMP;
            w_state_nxt = r_state - 3'd1;
         end
      end
   end

   assign w_trans = (w_move != MV_STAY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= 3'd0;
         r_trans_pulse <= 1'b0;
         r_dwell_cnt   <= '0;
         r_bad_entries <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_trans_pulse <= w_trans;
         if (w_trans)
            r_dwell_cnt <= '0;
         else if (bus.en && r_dwell_cnt != '1)
            r_dwell_cnt <= r_dwell_cnt + STAT_W'(1);
         // Clear beats a coincident entry into the worst state.
         if (bus.stat_clr)
            r_bad_entries <= '0;
         else if (w_move == MV_DEG && w_state_nxt == LAST && r_bad_entries != '1)
            r_bad_entries <= r_bad_entries + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            r_deg_thr[i] <= DEG_RST;
            r_imp_thr[i] <= IMP_RST;
            r_level[i]   <= (i == 0) ? LVL0_RST : LVLN_RST;
         end
      end else if (bus.cfg_we) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            if (bus.cfg_idx == 3'(i)) begin
               case (bus.cfg_sel)
                  2'd0:    r_deg_thr[i] <= bus.cfg_wdata[RAND_W-1:0];
                  2'd1:    r_imp_thr[i] <= bus.cfg_wdata[RAND_W-1:0];
                  2'd2:    r_level[i]   <= bus.cfg_wdata;
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.state_out   = r_state;
   assign bus.level_out   = w_level_cur;
   assign bus.trans_pulse = r_trans_pulse;
   assign bus.dwell_cnt   = r_dwell_cnt;
   assign bus.bad_entries = r_bad_entries;
endmodule
